fifo_full_gen: RTL

FIFO_FULL_GEN -- requirements
Module: fifo_full_gen

---
 rtl/fifo_pkg.sv | 37 +++
 rtl/fifo_sync_2ff.sv | 25 ++
 rtl/fifo_full_gen.sv | 85 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO write/read flag generators: Gray/binary
// conversion on zero-extended pointers of any width up to PTR_MAX_W, and depth derivation.
package fifo_pkg;

    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    function automatic int fifo_depth(input int abits);
        return 1 << abits;
    endfunction

    function automatic ptr_t ptr_mask(input int w);
        ptr_t m;
        if (w >= PTR_MAX_W) m = '1;
        else                m = (ptr_t'(1) << w) - ptr_t'(1);
        return m;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b, input int w);
        return (b ^ (b >> 1)) & ptr_mask(w);
    endfunction

    // Bits above w are masked off on entry, so the prefix XOR starts from zero there.
    function automatic ptr_t gray2bin(input ptr_t g, input int w);
        ptr_t gm;
        ptr_t b;
        gm = g & ptr_mask(w);
        b  = '0;
        b[PTR_MAX_W-1] = gm[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ gm[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchronizer for a multi-bit Gray-coded bus into the clk domain.
// Latency: two clk edges from a settled input to q.
// Backpressure: none; samples every edge.
module fifo_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/fifo_full_gen.sv
// Write-side pointer and full/almost-full/level generator of an async FIFO.
// Latency: flags/level registered one edge after a write; read advances visible on the 3rd wrclk edge.
// Backpressure: wr_en ignored while wr_full; optional sticky wr_ovf under FIFO_WR_OVF_EN.
module fifo_full_gen
    import fifo_pkg::*;
#(
    parameter int ABITS = 10,
    parameter int FTHR  = 2
) (
    input  logic             wrclk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [ABITS:0]   rd_gray_ptr,
`ifdef FIFO_WR_OVF_EN
    output logic             wr_ovf,
`endif
    output logic [ABITS-1:0] wr_addr,
    output logic             wr_ce,
    output logic [ABITS:0]   wr_gray_ptr,
    output logic             wr_full,
    output logic             wr_afull,
    output logic [ABITS:0]   wr_level
);

    localparam int DEPTH = fifo_depth(ABITS);
    localparam int PW    = ABITS + 1;

    logic [ABITS:0] wbin;
    logic [ABITS:0] wbin_next;
    logic [ABITS:0] gray_next;
    logic [ABITS:0] rq2;
    logic [ABITS:0] rbin_s;
    logic [ABITS:0] level_next;
    logic [ABITS:0] full_pattern;
    logic           full_next;
    logic           afull_next;

    fifo_sync_2ff #(
        .WIDTH (PW)
    ) u_rd_sync (
        .clk   (wrclk),
        .rst_n (rst_n),
        .d     (rd_gray_ptr),
        .q     (rq2)
    );

    assign wr_ce     = wr_en & ~wr_full;
    assign wbin_next = wbin + PW'(wr_ce);
    assign gray_next = PW'(bin2gray(ptr_t'(wbin_next), PW));
    assign rbin_s    = PW'(gray2bin(ptr_t'(rq2), PW));
    assign wr_addr   = wbin[ABITS-1:0];

    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    assign full_pattern = {~rq2[ABITS:ABITS-1], rq2[ABITS-2:0]};
    assign full_next    = (gray_next == full_pattern);
    assign level_next   = wbin_next - rbin_s;
    assign afull_next   = full_next | (level_next >= PW'(DEPTH - FTHR));

    always_ff @(posedge wrclk or negedge rst_n) begin
        if (!rst_n) begin
            wbin        <= '0;
            wr_gray_ptr <= '0;
            wr_full     <= 1'b0;
            wr_afull    <= 1'b0;
            wr_level    <= '0;
        end else begin
            wbin        <= wbin_next;
            wr_gray_ptr <= gray_next;
            wr_full     <= full_next;
            wr_afull    <= afull_next;
            wr_level    <= level_next;
        end
    end

`ifdef FIFO_WR_OVF_EN
    always_ff @(posedge wrclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ovf <= 1'b0;
        end else if (wr_en & wr_full) begin
            wr_ovf <= 1'b1;
        end
    end
`endif

endmodule
